// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the staged reset sequencer: FSM encoding and stage-select helper.
// Debug LEDs read these state codes, so the values are fixed.
package rst_seq_ctrl_pkg;

  localparam int STATE_W   = 3;
  localparam int MAX_STAGE = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RUN      = 3'd3
  } state_t;

  // One-hot select of the stage currently being released or acknowledged.
  function automatic logic [MAX_STAGE-1:0] stage_mask(input logic [2:0] idx);
    return MAX_STAGE'(1) << idx;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync_2ff.sv
// Generic two-flop bit synchroniser, reset value 0; used for the PLL lock and button inputs.
// Latency: 2 clk edges. No backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: after PLL lock, releases N reset domains in order, each gated on its ack.
// Latency: HOLD_CYCLES per stage plus ack wait (bounded by ACK_TIMEOUT). No backpressure; lock loss or soft reset aborts.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 1023,
  parameter int CNT_W       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] rst_out,
  output logic                all_ready,
  output logic                timeout_err,
  output logic [STATE_W-1:0]  state_dbg
);

  localparam int CNT_NEED = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;

  if (N_STAGES < 1 || N_STAGES > MAX_STAGE) begin : g_bad_stages
    $error("rst_seq_ctrl: N_STAGES must be 1..8");
  end
  if (HOLD_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_cycles
    $error("rst_seq_ctrl: HOLD_CYCLES and ACK_TIMEOUT must be >= 1");
  end
  if (CNT_NEED > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
    $error("rst_seq_ctrl: CNT_W too narrow for HOLD_CYCLES/ACK_TIMEOUT");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [2:0]       LAST_STAGE = 3'(N_STAGES - 1);

  state_t               state;
  logic [2:0]           stage;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 locked_s;
  logic [MAX_STAGE-1:0] mask_full;
  logic [N_STAGES-1:0]  cur_mask;
  logic                 cur_ack;
  logic                 abort;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  assign mask_full = stage_mask(stage);
  assign cur_mask  = mask_full[N_STAGES-1:0];
  // Only the ack of the stage being waited on matters.
  assign cur_ack   = |(stage_ack & cur_mask);
  assign abort     = !locked_s || soft_rst_req;
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      stage       <= 3'd0;
      cnt         <= '0;
      rst_out     <= '1;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
    end else if (state != ST_IDLE && abort) begin
      // timeout_err is left alone so the cause stays visible until the next attempt.
      state     <= ST_IDLE;
      stage     <= 3'd0;
      cnt       <= '0;
      rst_out   <= '1;
      all_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rst_out   <= '1;
          all_ready <= 1'b0;
          if (locked_s) begin
            state       <= ST_HOLD;
            stage       <= 3'd0;
            cnt         <= '0;
            timeout_err <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_out <= rst_out & ~cur_mask;
            cnt     <= '0;
            state   <= ST_WAIT_ACK;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_WAIT_ACK: begin
          if (cur_ack || cnt == ACK_LAST) begin
            if (!cur_ack) timeout_err <= 1'b1;
            cnt <= '0;
            if (stage == LAST_STAGE) begin
              state     <= ST_RUN;
              all_ready <= 1'b1;
              rst_out   <= '0;
            end else begin
              stage <= stage + 3'd1;
              state <= ST_HOLD;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RUN: begin
          all_ready <= 1'b1;
          rst_out   <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
